// File: rtl/shazam_pkg.sv
// Shared constants and types for the spectral peak picker: band layout,
// peak record and the emitter state encoding.
package shazam_pkg;

    localparam int MAG_W     = 16;
    localparam int IDX_W     = 11;
    localparam int NUM_BANDS = 6;
    localparam int BAND_W    = 3;

    // Lower edge of each band; the last entry closes the top band.
    localparam logic [IDX_W-1:0] BAND_EDGE [0:NUM_BANDS] = '{
        11'd0, 11'd10, 11'd20, 11'd40, 11'd80, 11'd160, 11'd512
    };

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [MAG_W-1:0] mag;
    } peak_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } emit_state_e;

    // True when a bin index falls inside band b (half-open interval).
    function automatic logic in_band(input logic [IDX_W-1:0] idx, input int b);
        in_band = (idx >= BAND_EDGE[b]) && (idx < BAND_EDGE[b+1]);
    endfunction

endpackage

// File: rtl/band_max_tracker.sv
// Running maximum of one frequency band. result_o is the band maximum
// including the sample presented this cycle, which is what a frame-end
// snapshot must capture.
module band_max_tracker
    import shazam_pkg::*;
#(
    parameter logic [MAG_W-1:0] MIN_MAG = 16'd0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             discard_i,
    input  logic             update_i,
    input  logic             snapshot_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [MAG_W-1:0] mag_i,
    output peak_t            result_o
);

    peak_t max_q;
    peak_t max_d;
    peak_t base_s;
    peak_t cand_s;

    // Candidate max: a discarded partial frame compares against an empty band.
    always_comb begin
        base_s = discard_i ? '0 : max_q;
        if (update_i && (mag_i > base_s.mag) && (mag_i > MIN_MAG)) begin
            cand_s.found = 1'b1;
            cand_s.idx   = idx_i;
            cand_s.mag   = mag_i;
        end else begin
            cand_s = base_s;
        end
        if (snapshot_i) begin
            max_d = '0;
        end else begin
            max_d = cand_s;
        end
    end

    assign result_o = cand_s;

    // Hold the running max; cleared by reset and at every frame end.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

endmodule

// File: rtl/spectral_peak_picker.sv
// Per-frame, per-band peak finder behind the FFT magnitude stream. Frames are
// accumulated in band trackers, snapshotted at the last bin and drained one
// band per handshake while the next frame accumulates.
module spectral_peak_picker
    import shazam_pkg::*;
#(
    parameter int               FFT_LENGTH = 1024,
    parameter logic [MAG_W-1:0] MIN_MAG    = 16'd0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [MAG_W-1:0]  magnitude_i,
    input  logic              magnitude_ready_i,
    input  logic [IDX_W-1:0]  index_i,
    output logic              peak_valid_o,
    input  logic              peak_ready_i,
    output logic [BAND_W-1:0] peak_band_o,
    output logic [IDX_W-1:0]  peak_index_o,
    output logic [MAG_W-1:0]  peak_mag_o,
    output logic              peak_found_o,
    output logic              frame_last_o,
    output logic              overflow_o,
    output logic              resync_o
);

    localparam logic [IDX_W-1:0]  HALF_BINS = IDX_W'(FFT_LENGTH / 2);
    localparam logic [IDX_W-1:0]  LAST_BIN  = IDX_W'(FFT_LENGTH / 2 - 1);
    localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NUM_BANDS - 1);

    logic              accept_s;
    logic              restart_s;
    logic              frame_end_s;
    logic [IDX_W-1:0]  last_idx_q;
    logic [IDX_W-1:0]  last_idx_d;
    logic              started_q;
    logic              started_d;
    logic              resync_q;
    logic              resync_d;
    logic [BAND_W-1:0] band_q;
    logic [BAND_W-1:0] band_nxt_s;
    emit_state_e       state_q;
    peak_t             cand_s [NUM_BANDS];
    peak_t             snap_q [NUM_BANDS];
    peak_t             out_q;
    logic [BAND_W-1:0] out_band_q;
    logic              valid_q;
    logic              last_q;
    logic              overflow_q;

    // Input qualification and index sequencing of the accumulator.
    always_comb begin
        accept_s    = magnitude_ready_i && (index_i < HALF_BINS);
        restart_s   = accept_s && started_q && (index_i <= last_idx_q);
        frame_end_s = accept_s && (index_i == LAST_BIN);
        band_nxt_s  = band_q + 3'd1;
        resync_d    = restart_s;
        if (accept_s) begin
            last_idx_d = index_i;
            started_d  = !frame_end_s;
        end else begin
            last_idx_d = last_idx_q;
            started_d  = started_q;
        end
    end

    // Sequencing state: last accepted index, frame-started flag, resync pulse.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_idx_q <= 11'd0;
            started_q  <= 1'b0;
            resync_q   <= 1'b0;
        end else begin
            last_idx_q <= last_idx_d;
            started_q  <= started_d;
            resync_q   <= resync_d;
        end
    end

    for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
        band_max_tracker #(
            .MIN_MAG (MIN_MAG)
        ) u_tracker (
            .clk_i      (clk_i),
            .reset_i    (reset_i),
            .discard_i  (restart_s),
            .update_i   (accept_s && in_band(index_i, b)),
            .snapshot_i (frame_end_s),
            .idx_i      (index_i),
            .mag_i      (magnitude_i),
            .result_o   (cand_s[b])
        );
    end

    // Emitter FSM: snapshot on frame end when idle, drain one band per handshake.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            band_q     <= 3'd0;
            out_q      <= '0;
            out_band_q <= 3'd0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            overflow_q <= 1'b0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                snap_q[b] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_end_s) begin
                        snap_q     <= cand_s;
                        state_q    <= ST_EMIT;
                        band_q     <= 3'd0;
                        out_q      <= cand_s[0];
                        out_band_q <= 3'd0;
                        valid_q    <= 1'b1;
                        last_q     <= 1'b0;
                    end
                end
                ST_EMIT: begin
                    if (frame_end_s) begin
                        overflow_q <= 1'b1;
                    end
                    if (peak_ready_i) begin
                        if (band_q == LAST_BAND) begin
                            state_q    <= ST_IDLE;
                            band_q     <= 3'd0;
                            out_q      <= '0;
                            out_band_q <= 3'd0;
                            valid_q    <= 1'b0;
                            last_q     <= 1'b0;
                        end else begin
                            band_q     <= band_nxt_s;
                            out_q      <= snap_q[band_nxt_s];
                            out_band_q <= band_nxt_s;
                            last_q     <= (band_nxt_s == LAST_BAND);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign peak_valid_o = valid_q;
    assign peak_band_o  = out_band_q;
    assign peak_index_o = out_q.idx;
    assign peak_mag_o   = out_q.mag;
    assign peak_found_o = out_q.found;
    assign frame_last_o = last_q;
    assign overflow_o   = overflow_q;
    assign resync_o     = resync_q;

endmodule

// File: tb/tb_spectral_peak_picker.sv
// Bench for spectral_peak_picker: two instances (noise floor 0 and 100) share
// the stimulus; a list-based frame model predicts every output each cycle.
module tb_spectral_peak_picker;
    import shazam_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, mr, pready;
    logic [MAG_W-1:0] mag;
    logic [IDX_W-1:0] idx;

    logic a_valid, a_found, a_last, a_ovf, a_resync;
    logic b_valid, b_found, b_last, b_ovf, b_resync;
    logic [2:0] a_band, b_band;
    logic [IDX_W-1:0] a_idx, b_idx;
    logic [MAG_W-1:0] a_mag, b_mag;

    spectral_peak_picker #(.FFT_LENGTH(1024), .MIN_MAG(16'd0)) dut_a (
        .clk_i(clk), .reset_i(reset), .magnitude_i(mag), .magnitude_ready_i(mr),
        .index_i(idx), .peak_valid_o(a_valid), .peak_ready_i(pready),
        .peak_band_o(a_band), .peak_index_o(a_idx), .peak_mag_o(a_mag),
        .peak_found_o(a_found), .frame_last_o(a_last), .overflow_o(a_ovf),
        .resync_o(a_resync));

    spectral_peak_picker #(.FFT_LENGTH(1024), .MIN_MAG(16'd100)) dut_b (
        .clk_i(clk), .reset_i(reset), .magnitude_i(mag), .magnitude_ready_i(mr),
        .index_i(idx), .peak_valid_o(b_valid), .peak_ready_i(pready),
        .peak_band_o(b_band), .peak_index_o(b_idx), .peak_mag_o(b_mag),
        .peak_found_o(b_found), .frame_last_o(b_last), .overflow_o(b_ovf),
        .resync_o(b_resync));

    typedef struct { int band; int found0, idx0, mag0, found1, idx1, mag1; } exp_t;
    typedef struct { int band; int found; int idx; int mag; int last; } vec_t;

    localparam int EDGE [0:6] = '{0, 10, 20, 40, 80, 160, 512};
    localparam int FLOOR_B = 100;

    exp_t exp_q[$];
    int   s_idx[$];
    int   s_mag[$];
    int   last_seen = 0;
    bit   ovf_exp = 1'b0;
    bit   resync_exp = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   hs_count = 0;
    int   resync_cnt = 0;
    vec_t tbl [6];

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Strongest bin of a band in the collected frame, lowest index on ties.
    function automatic void band_peak(input int b, input int floor_v,
                                      output int f, output int bi, output int bm);
        f = 0; bi = 0; bm = 0;
        for (int k = 0; k < s_idx.size(); k++) begin
            if (s_idx[k] >= EDGE[b] && s_idx[k] < EDGE[b+1] &&
                s_mag[k] > bm && s_mag[k] > floor_v) begin
                f = 1; bi = s_idx[k]; bm = s_mag[k];
            end
        end
    endfunction

    function automatic void close_frame(input bit busy);
        exp_t e;
        if (busy) begin
            ovf_exp = 1'b1;
        end else begin
            for (int b = 0; b < 6; b++) begin
                e.band = b;
                band_peak(b, 0, e.found0, e.idx0, e.mag0);
                band_peak(b, FLOOR_B, e.found1, e.idx1, e.mag1);
                exp_q.push_back(e);
            end
        end
    endfunction

    task automatic compare_outputs();
        bit ev;
        ev = exp_q.size() > 0;
        check("valid_a", int'(a_valid), int'(ev));
        check("valid_b", int'(b_valid), int'(ev));
        check("overflow_a", int'(a_ovf), int'(ovf_exp));
        check("overflow_b", int'(b_ovf), int'(ovf_exp));
        check("resync_a", int'(a_resync), int'(resync_exp));
        check("resync_b", int'(b_resync), int'(resync_exp));
        if (ev) begin
            check("band_a", int'(a_band), exp_q[0].band);
            check("band_b", int'(b_band), exp_q[0].band);
            check("last_a", int'(a_last), int'(exp_q[0].band == 5));
            check("last_b", int'(b_last), int'(exp_q[0].band == 5));
            check("found_a", int'(a_found), exp_q[0].found0);
            check("idx_a", int'(a_idx), exp_q[0].idx0);
            check("mag_a", int'(a_mag), exp_q[0].mag0);
            check("found_b", int'(b_found), exp_q[0].found1);
            check("idx_b", int'(b_idx), exp_q[0].idx1);
            check("mag_b", int'(b_mag), exp_q[0].mag1);
        end else begin
            check("last_idle_a", int'(a_last), 0);
            check("last_idle_b", int'(b_last), 0);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check after it.
    task automatic step(input bit rst, input bit rdy, input bit v, input int i, input int m);
        bit busy;
        reset = rst; pready = rdy; mr = v;
        idx = i[IDX_W-1:0]; mag = m[MAG_W-1:0];
        if (a_valid && rdy && !rst) hs_count++;
        @(posedge clk);
        busy = exp_q.size() > 0;
        if (rst) begin
            exp_q.delete(); s_idx.delete(); s_mag.delete();
            ovf_exp = 1'b0; resync_exp = 1'b0;
        end else begin
            if (busy && rdy) void'(exp_q.pop_front());
            resync_exp = 1'b0;
            if (v && i < 512) begin
                if (s_idx.size() > 0 && i <= last_seen) begin
                    s_idx.delete(); s_mag.delete(); resync_exp = 1'b1;
                end
                s_idx.push_back(i); s_mag.push_back(m); last_seen = i;
                if (i == 511) begin
                    close_frame(busy);
                    s_idx.delete(); s_mag.delete();
                end
            end
        end
        #1;
        if (a_resync) resync_cnt++;
        compare_outputs();
    endtask

    task automatic send_ramp(input int lo, input int hi, input bit rdy);
        for (int i = lo; i <= hi; i++) step(1'b0, rdy, 1'b1, i, i + 1);
    endtask

    // Walk the six outputs of a frame against the table with ready held high.
    task automatic run_table(input bit use_b);
        for (int k = 0; k < 6; k++) begin
            check("tbl_valid", use_b ? int'(b_valid) : int'(a_valid), 1);
            check("tbl_band", use_b ? int'(b_band) : int'(a_band), tbl[k].band);
            check("tbl_found", use_b ? int'(b_found) : int'(a_found), tbl[k].found);
            check("tbl_idx", use_b ? int'(b_idx) : int'(a_idx), tbl[k].idx);
            check("tbl_mag", use_b ? int'(b_mag) : int'(a_mag), tbl[k].mag);
            check("tbl_last", use_b ? int'(b_last) : int'(a_last), tbl[k].last);
            step(1'b0, 1'b1, 1'b0, 0, 0);
        end
        check("tbl_drained", use_b ? int'(b_valid) : int'(a_valid), 0);
    endtask

    task automatic load_ramp_table();
        tbl[0] = '{0, 1, 9, 10, 0};
        tbl[1] = '{1, 1, 19, 20, 0};
        tbl[2] = '{2, 1, 39, 40, 0};
        tbl[3] = '{3, 1, 79, 80, 0};
        tbl[4] = '{4, 1, 159, 160, 0};
        tbl[5] = '{5, 1, 511, 512, 1};
    endtask

    initial begin
        int cur, nxt, last_sent, r;
        bit rdy, started;
        reset = 1'b1; mr = 1'b0; pready = 1'b0; idx = '0; mag = '0;
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        check("rst_valid", int'(a_valid), 0);
        check("rst_overflow", int'(a_ovf), 0);
        check("rst_band", int'(a_band), 0);

        // 1: ramp frame and latency
        load_ramp_table();
        send_ramp(0, 510, 1'b1);
        check("lat_before_last", int'(a_valid), 0);
        step(1'b0, 1'b1, 1'b1, 511, 512);
        run_table(1'b0);

        // 2: tie and noise floor, checked on the floor-100 instance
        for (int i = 0; i < 512; i++) step(1'b0, 1'b1, 1'b1, i, (i == 25 || i == 30) ? 500 : 50);
        for (int k = 0; k < 6; k++) tbl[k] = '{k, 0, 0, 0, int'(k == 5)};
        tbl[2] = '{2, 1, 25, 500, 0};
        run_table(1'b1);

        // 3: backpressure across two frames, then release
        send_ramp(0, 511, 1'b0);
        send_ramp(0, 511, 1'b0);
        check("bp_hold_band", int'(a_band), 0);
        check("bp_hold_idx", int'(a_idx), 9);
        check("bp_overflow", int'(a_ovf), 1);
        load_ramp_table();
        run_table(1'b0);
        step(1'b0, 1'b1, 1'b0, 0, 0);

        // 4: resync on restart
        step(1'b1, 1'b1, 1'b0, 0, 0);
        resync_cnt = 0;
        send_ramp(0, 200, 1'b1);
        send_ramp(0, 511, 1'b1);
        check("resync_count", resync_cnt, 1);
        load_ramp_table();
        run_table(1'b0);

        // 5: back-to-back frames with out-of-range bins and 21-cycle gaps
        step(1'b1, 1'b1, 1'b0, 0, 0);
        hs_count = 0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 1024; i++) step(1'b0, 1'b1, 1'b1, i, $urandom_range(0, 300));
            for (int g = 0; g < 21; g++) step(1'b0, 1'b1, 1'b0, 0, 0);
        end
        check("b2b_peaks", hs_count, 18);
        check("b2b_overflow", int'(a_ovf), 0);

        // 6: reset during emission at band 3
        step(1'b1, 1'b1, 1'b0, 0, 0);
        send_ramp(0, 511, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 0, 0);
        check("mid_emit_band", int'(a_band), 3);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        check("reset_kills_valid", int'(a_valid), 0);
        step(1'b0, 1'b1, 1'b0, 0, 0);
        check("post_reset_idle", int'(a_valid), 0);
        send_ramp(0, 511, 1'b1);
        load_ramp_table();
        run_table(1'b0);

        // Randomized frames: gaps, restarts, ignored bins, random backpressure
        step(1'b1, 1'b1, 1'b0, 0, 0);
        for (int f = 0; f < 30; f++) begin
            cur = 0; last_sent = 0; started = 1'b0;
            while (cur <= 511) begin
                r = $urandom_range(0, 99);
                rdy = ($urandom_range(0, 3) != 0);
                if (r < 5) begin
                    step(1'b0, rdy, 1'b0, 0, 0);
                end else if (r < 8) begin
                    step(1'b0, rdy, 1'b1, $urandom_range(512, 1023), $urandom_range(0, 150));
                end else begin
                    if (r < 10 && started) nxt = $urandom_range(0, last_sent);
                    else nxt = cur;
                    step(1'b0, rdy, 1'b1, nxt, $urandom_range(0, 150));
                    started = 1'b1; last_sent = nxt;
                    cur = nxt + $urandom_range(1, 4);
                    if (nxt < 511 && cur > 511) cur = 511;
                end
            end
        end
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
